// File: rtl/hpdcache_pkg.sv
// Shared cache package: elaboration-time helpers used across cache sub-blocks.
package hpdcache_pkg;

   // Width of a binary index selecting one of n items; never narrower than 1 bit.
   function automatic int hpdcache_idxw(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/hpdcache_1hot_to_binary.sv
// One-hot to binary index encoder; an all-zero input yields index 0.
module hpdcache_1hot_to_binary #(
   parameter int N    = 4,
   parameter int IDXW = 2
) (
   input  logic [N-1:0]    i_onehot,
   output logic [IDXW-1:0] o_idx
);

   always_comb begin
      o_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (i_onehot[i]) o_idx = o_idx | IDXW'(i);
      end
   end

endmodule

// File: rtl/hpdcache_wrrarb.sv
// Weighted round-robin arbiter: a winner keeps the grant for up to weight
// consecutive accepted beats; the grant is frozen while the consumer stalls.
module hpdcache_wrrarb
   import hpdcache_pkg::*;
#(
   parameter int N    = 4,
   parameter int WW   = 4,
   parameter int IDXW = hpdcache_idxw(N)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N-1:0]    req_i,
   input  logic [N*WW-1:0] weight_i,
   input  logic            ready_i,
   output logic [N-1:0]    gnt_o,
   output logic [IDXW-1:0] gnt_idx_o,
   output logic            valid_o
);

   if (N < 1) begin : g_bad_n
      $error("hpdcache_wrrarb: N must be >= 1");
   end

   logic [N-1:0]  r_gnt_q;
   logic          r_wait_q;
   logic [WW-1:0] r_credit_q;
   logic          r_sticky_q;

   logic [N-1:0]  w_mask, w_req_m, w_pick_m, w_pick_a, w_rr_gnt, w_gnt;
   logic          w_hold, w_accept, w_cont;
   logic [WW-1:0] w_wsel, w_w;

   // Bits strictly above the last winner; reset state (MSB) masks everything.
   assign w_mask   = ~(r_gnt_q | (r_gnt_q - N'(1)));
   assign w_req_m  = req_i & w_mask;
   // Lowest-set-bit isolation acts as the priority one-hot encoder.
   assign w_pick_m = w_req_m & (~w_req_m + N'(1));
   assign w_pick_a = req_i & (~req_i + N'(1));
   assign w_rr_gnt = (|w_req_m) ? w_pick_m : w_pick_a;

   assign w_hold   = r_sticky_q & (|(req_i & r_gnt_q));
   assign w_gnt    = w_hold ? r_gnt_q : w_rr_gnt;
   assign gnt_o    = r_wait_q ? r_gnt_q : w_gnt;
   assign valid_o  = |gnt_o;
   assign w_accept = valid_o & ready_i;
   assign w_cont   = (gnt_o == r_gnt_q) & r_sticky_q;

   always_comb begin
      w_wsel = '0;
      for (int k = 0; k < N; k++) begin
         if (gnt_o[k]) w_wsel = w_wsel | weight_i[k*WW +: WW];
      end
   end
   assign w_w = (w_wsel == '0) ? WW'(1) : w_wsel;

   hpdcache_1hot_to_binary #(.N(N), .IDXW(IDXW)) u_idx (
      .i_onehot (gnt_o),
      .o_idx    (gnt_idx_o)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_gnt_q    <= N'(1) << (N - 1);
         r_wait_q   <= 1'b0;
         r_credit_q <= '0;
         r_sticky_q <= 1'b0;
      end else begin
         r_wait_q <= ~ready_i & (r_wait_q | (|req_i));
         if (!r_wait_q && (|req_i)) r_gnt_q <= w_gnt;
         if (w_accept) begin
            if (w_cont) begin
               r_credit_q <= r_credit_q - WW'(1);
               r_sticky_q <= (r_credit_q > WW'(1));
            end else begin
               r_credit_q <= w_w - WW'(1);
               r_sticky_q <= (w_w > WW'(1));
            end
         end
      end
   end

`ifndef SYNTHESIS
   a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));
   a_gntq_onehot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot(r_gnt_q));
   a_wait_stable : assert property (@(posedge clk_i) disable iff (rst_i) r_wait_q |-> $stable(gnt_o));
   a_gnt_subset  : assert property (@(posedge clk_i) disable iff (rst_i)
                                    !r_wait_q |-> ((gnt_o & ~req_i) == '0));
   a_no_withdraw : assert property (@(posedge clk_i) disable iff (rst_i)
                                    r_wait_q |-> (|(req_i & r_gnt_q)));
`endif

endmodule
